// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX field splitter.
// Byte classes, CheckSum tag, error codes and parser states.
package fix_pkg;

  localparam logic [7:0] SOH_BYTE  = 8'h01;
  localparam logic [7:0] EQ_BYTE   = 8'h3D;
  localparam logic [7:0] ZERO_BYTE = 8'h30;
  localparam logic [7:0] NINE_BYTE = 8'h39;

  localparam int CHECKSUM_TAG = 10;

  localparam logic [1:0] E_TAG_CHAR = 2'd0;
  localparam logic [1:0] E_TAG_LEN  = 2'd1;
  localparam logic [1:0] E_VAL_LEN  = 2'd2;
  localparam logic [1:0] E_CKS_FMT  = 2'd3;

  typedef enum logic [1:0] {
    S_TAG,
    S_VAL,
    S_ERR
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ZERO_BYTE) && (b <= NINE_BYTE);
  endfunction

endpackage

// File: rtl/fix_cks_accum.sv
// Running mod-256 byte sum and tag-10 CheckSum parse/compare.
// Format faults are reported combinationally; done/ok are registered.
module fix_cks_accum
  import fix_pkg::*;
#(
  parameter logic [7:0] SOH = SOH_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       accept,
  input  logic       arm,
  input  logic       val_byte,
  input  logic       close,
  output logic       fmt_bad_byte,
  output logic       fmt_bad_close,
  output logic       cks_done,
  output logic       cks_ok
);

  logic [7:0] sum8;
  logic [7:0] fstart;
  logic [7:0] expected;
  logic       armed;
  logic [1:0] cnt;
  logic [9:0] value;
  logic [7:0] sum_next;
  logic       good_close;

  assign sum_next      = sum8 + din;
  assign fmt_bad_byte  = armed && (!is_digit(din) || (cnt == 2'd3));
  assign fmt_bad_close = armed && (cnt != 2'd3);
  assign good_close    = close && armed && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum8     <= '0;
      fstart   <= '0;
      expected <= '0;
      armed    <= 1'b0;
      cnt      <= '0;
      value    <= '0;
      cks_done <= 1'b0;
      cks_ok   <= 1'b0;
    end else begin
      cks_done <= good_close;
      cks_ok   <= good_close && (value[7:0] == expected);
      if (accept) begin
        // A verified CheckSum closes the message: sums restart at zero.
        if (good_close) begin
          sum8   <= '0;
          fstart <= '0;
        end else begin
          sum8 <= sum_next;
          if (din == SOH)
            fstart <= sum_next;
        end
        if (arm) begin
          armed    <= 1'b1;
          expected <= fstart;
          cnt      <= '0;
          value    <= '0;
        end else if (din == SOH) begin
          armed <= 1'b0;
        end else if (val_byte && armed) begin
          cnt   <= cnt + 2'd1;
          value <= (value << 3) + (value << 1)
                 + {6'b0, din[3:0]};
        end
      end
    end
  end

endmodule

// File: rtl/fix_field_splitter.sv
// Splits a FIX byte stream into tag=value<SOH> fields.
// Emits tag, value bytes, field end with length, errors and CheckSum.
module fix_field_splitter
  import fix_pkg::*;
#(
  parameter int         TAG_DIGITS_MAX = 5,
  parameter int         TAG_W          = 17,
  parameter int         LEN_W          = 12,
  parameter logic [7:0] SOH            = SOH_BYTE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic [TAG_W-1:0] tag_out,
  output logic             tag_valid,
  output logic [7:0]       val_data,
  output logic             val_valid,
  output logic             field_end,
  output logic [LEN_W-1:0] val_len,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             cks_done,
  output logic             cks_ok
);

  localparam int DW = $clog2(TAG_DIGITS_MAX + 1);

  state_t           state, state_n;
  logic [TAG_W-1:0] tag_acc, tag_acc_n, tag_x10;
  logic [DW-1:0]    digits, digits_n;
  logic [LEN_W-1:0] len, len_n;

  logic [TAG_W-1:0] tag_out_n;
  logic             tag_valid_n, val_valid_n;
  logic             field_end_n, err_n;
  logic [7:0]       val_data_n;
  logic [LEN_W-1:0] val_len_n;
  logic [1:0]       err_code_n;

  logic cks_arm, val_byte, close;
  logic fmt_bad_byte, fmt_bad_close;

  assign tag_x10 = (tag_acc << 3) + (tag_acc << 1);

  fix_cks_accum #(.SOH(SOH)) u_cks (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .accept       (din_valid),
    .arm          (cks_arm),
    .val_byte     (val_byte),
    .close        (close),
    .fmt_bad_byte (fmt_bad_byte),
    .fmt_bad_close(fmt_bad_close),
    .cks_done     (cks_done),
    .cks_ok       (cks_ok)
  );

  always_comb begin
    state_n     = state;
    tag_acc_n   = tag_acc;
    digits_n    = digits;
    len_n       = len;
    tag_out_n   = tag_out;
    tag_valid_n = 1'b0;
    val_data_n  = val_data;
    val_valid_n = 1'b0;
    field_end_n = 1'b0;
    val_len_n   = val_len;
    err_n       = 1'b0;
    err_code_n  = err_code;
    cks_arm     = 1'b0;
    val_byte    = 1'b0;
    close       = 1'b0;
    if (din_valid) begin
      unique case (state)
        S_TAG: begin
          // Any non-digit ends the tag attempt, so the accumulator clears.
          tag_acc_n = '0;
          digits_n  = '0;
          if (is_digit(din)) begin
            if (digits == DW'(TAG_DIGITS_MAX)) begin
              err_n      = 1'b1;
              err_code_n = E_TAG_LEN;
              state_n    = S_ERR;
            end else begin
              tag_acc_n = tag_x10 + TAG_W'(din[3:0]);
              digits_n  = digits + DW'(1);
            end
          end else if (din == EQ_BYTE) begin
            if (digits == '0) begin
              err_n      = 1'b1;
              err_code_n = E_TAG_LEN;
              state_n    = S_ERR;
            end else begin
              tag_out_n   = tag_acc;
              tag_valid_n = 1'b1;
              len_n       = '0;
              state_n     = S_VAL;
              cks_arm     = (tag_acc == TAG_W'(CHECKSUM_TAG));
            end
          end else if (din == SOH) begin
            err_n      = 1'b1;
            err_code_n = E_TAG_LEN;
          end else begin
            err_n      = 1'b1;
            err_code_n = E_TAG_CHAR;
            state_n    = S_ERR;
          end
        end
        S_VAL: begin
          if (din == SOH) begin
            close   = 1'b1;
            state_n = S_TAG;
            if (fmt_bad_close) begin
              err_n      = 1'b1;
              err_code_n = E_CKS_FMT;
            end else begin
              field_end_n = 1'b1;
              val_len_n   = len;
            end
          end else if (len == '1) begin
            err_n      = 1'b1;
            err_code_n = E_VAL_LEN;
            state_n    = S_ERR;
          end else if (fmt_bad_byte) begin
            err_n      = 1'b1;
            err_code_n = E_CKS_FMT;
            state_n    = S_ERR;
          end else begin
            val_data_n  = din;
            val_valid_n = 1'b1;
            len_n       = len + LEN_W'(1);
            val_byte    = 1'b1;
          end
        end
        S_ERR: begin
          if (din == SOH)
            state_n = S_TAG;
        end
        default: state_n = S_TAG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_TAG;
      tag_acc   <= '0;
      digits    <= '0;
      len       <= '0;
      tag_out   <= '0;
      tag_valid <= 1'b0;
      val_data  <= '0;
      val_valid <= 1'b0;
      field_end <= 1'b0;
      val_len   <= '0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_n;
      tag_acc   <= tag_acc_n;
      digits    <= digits_n;
      len       <= len_n;
      tag_out   <= tag_out_n;
      tag_valid <= tag_valid_n;
      val_data  <= val_data_n;
      val_valid <= val_valid_n;
      field_end <= field_end_n;
      val_len   <= val_len_n;
      err       <= err_n;
      err_code  <= err_code_n;
    end
  end

endmodule

// File: tb/tb_fix_field_splitter.sv
// Directed bench for fix_field_splitter: per-byte expected events
// from a vector table, plus gap, reset and length-limit sequences.
module tb_fix_field_splitter;

  logic        clk = 0;
  logic        reset = 1;
  logic [7:0]  din = 0;
  logic        din_valid = 0;
  logic [16:0] tag_out;
  logic        tag_valid;
  logic [7:0]  val_data;
  logic        val_valid;
  logic        field_end;
  logic [11:0] val_len;
  logic        err;
  logic [1:0]  err_code;
  logic        cks_done;
  logic        cks_ok;

  int total = 0;
  int bad = 0;

  fix_field_splitter dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .tag_out  (tag_out),
    .tag_valid(tag_valid),
    .val_data (val_data),
    .val_valid(val_valid),
    .field_end(field_end),
    .val_len  (val_len),
    .err      (err),
    .err_code (err_code),
    .cks_done (cks_done),
    .cks_ok   (cks_ok)
  );

  always #5 clk = ~clk;

  // ev chars: '.' none, T tag, V value byte, F field end,
  // E error, K field end + CheckSum ok, N field end + CheckSum bad.
  typedef struct {
    bit    rst;
    string s;
    string ev;
    int    tag;
    int    len;
    int    code;
  } vec_t;

  vec_t vecs[14];

  task automatic step(input logic [7:0] b, input logic v);
    din       = b;
    din_valid = v;
    @(posedge clk);
    #1;
    din_valid = 0;
  endtask

  task automatic check(input string name, input logic ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: tv=%b tag=%0d vv=%b data=%h fe=%b len=%0d err=%b code=%0d cd=%b ck=%b",
               name, tag_valid, tag_out, val_valid, val_data, field_end,
               val_len, err, err_code, cks_done, cks_ok);
    end
  endtask

  task automatic check_ev(input string name, input logic [7:0] b,
                          input logic [7:0] e, input vec_t v);
    logic ok;
    logic xtv, xvv, xfe, xer, xcd;
    xtv = (e == "T");
    xvv = (e == "V");
    xfe = (e == "F") || (e == "K") || (e == "N");
    xer = (e == "E");
    xcd = (e == "K") || (e == "N");
    ok = (tag_valid == xtv) && (val_valid == xvv) && (field_end == xfe)
      && (err == xer) && (cks_done == xcd);
    if (xtv && (tag_out != 17'(v.tag))) ok = 0;
    if (xvv && (val_data != b)) ok = 0;
    if (xfe && (val_len != 12'(v.len))) ok = 0;
    if (xer && (err_code != 2'(v.code))) ok = 0;
    if (xcd && (cks_ok != (e == "K"))) ok = 0;
    if (!ok)
      $display("  expected ev=%s tag=%0d len=%0d code=%0d on byte %h",
               e, v.tag, v.len, v.code, b);
    check(name, ok);
  endtask

  task automatic do_reset();
    reset = 1;
    step(8'h01, 1);
    reset = 0;
  endtask

  task automatic check_zero(input string name);
    check(name, tag_out == 0 && !tag_valid && val_data == 0 && !val_valid
              && !field_end && val_len == 0 && !err && err_code == 0
              && !cks_done && !cks_ok);
  endtask

  task automatic run_vec(input vec_t v, input bit gaps);
    logic [7:0] b;
    logic [7:0] e;
    if (v.rst) do_reset();
    for (int i = 0; i < v.s.len(); i++) begin
      b = v.s.getc(i);
      if (b == "|") b = 8'h01;
      e = v.ev.getc(i);
      step(b, 1);
      check_ev({v.s, " @", $sformatf("%0d", i)}, b, e, v);
      if (gaps) begin
        step(8'h01, 0);
        check_ev({v.s, " gap"}, 8'h01, ".", v);
      end
    end
  endtask

  initial begin
    int errs;
    vec_t t;

    vecs[0]  = '{1, "8=FIX.4.2|", ".TVVVVVVVF", 8, 7, 0};
    vecs[1]  = '{1, "8=A|",       ".TVF",       8, 1, 0};
    vecs[2]  = '{0, "10=183|",    "..TVVVK",    10, 3, 0};
    vecs[3]  = '{0, "8=A|",       ".TVF",       8, 1, 0};
    vecs[4]  = '{0, "10=184|",    "..TVVVN",    10, 3, 0};
    vecs[5]  = '{0, "12345=X|",   ".....TVF",   12345, 1, 0};
    vecs[6]  = '{0, "123456=X|",  ".....E...",  0, 0, 1};
    vecs[7]  = '{0, "35=D|",      "..TVF",      35, 1, 0};
    vecs[8]  = '{0, "3a=1|",      ".E...",      0, 0, 0};
    vecs[9]  = '{0, "=5|",        "E..",        0, 0, 1};
    vecs[10] = '{0, "10=18|",     "..TVVE",     10, 0, 3};
    vecs[11] = '{0, "10=1a3|",    "..TVE..",    10, 0, 3};
    vecs[12] = '{0, "|",          "E",          0, 0, 1};
    vecs[13] = '{0, "7=|",        ".TF",        7, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_zero("reset state");

    for (int k = 0; k < 14; k++)
      run_vec(vecs[k], 0);

    // Same field with idle cycles between bytes.
    run_vec(vecs[0], 1);

    // Reset in the middle of a value, then a fresh message.
    t = '{0, "55=AB", "..TVV", 55, 0, 0};
    run_vec(t, 0);
    do_reset();
    check_zero("mid-field reset");
    t = '{0, "9=1|", ".TVF", 9, 1, 0};
    run_vec(t, 0);
    t = '{0, "10=168|", "..TVVVK", 10, 3, 0};
    run_vec(t, 0);

    // Longest legal value, then one byte too many.
    t = '{0, "1=", ".T", 1, 0, 0};
    run_vec(t, 0);
    errs = 0;
    for (int i = 0; i < 4095; i++) begin
      step("a", 1);
      if (!val_valid || val_data != "a" || err) errs++;
    end
    check("max value bytes", errs == 0);
    step(8'h01, 1);
    check("max value end", field_end && val_len == 12'd4095 && !err);
    t = '{0, "2=", ".T", 2, 0, 0};
    run_vec(t, 0);
    for (int i = 0; i < 4095; i++) step("b", 1);
    step("b", 1);
    check("value too long", err && err_code == 2'd2 && !val_valid);
    step(8'h01, 1);
    check("too long close", !field_end && !err && !val_valid);
    t = '{0, "3=Z|", ".TVF", 3, 1, 0};
    run_vec(t, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
